game_timekeeper: RTL and testbench

//  Game-time controller for the escape-room game FSM. Divides Clk into in-game minutes and

---
 rtl/game_timekeeper.sv | 161 ++++++++++++++++
 tb/tb_game_timekeeper.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/game_timekeeper.sv
// Game-time controller: divides Clk into in-game minutes, schedules professor visits,
// times quiz windows and flags the overall time limit. Optional feature macro: PROF_LFSR_EN.
module game_timekeeper #(
    parameter int TICKS_PER_MIN = 100_000_000,
    parameter int MAX_TIME      = 120,
    parameter int PROF_MIN_GAP  = 10,
    parameter int PROF_MAX_GAP  = 25,
    parameter int QUIZ_WINDOW   = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       clr,
    input  logic       hold,
    input  logic       prof_ack,
    input  logic       quiz_done,
    output logic [7:0] minutes,
    output logic       min_tick,
    output logic       professor,
    output logic       quiz_active,
    output logic       quiz_timeout,
    output logic       time_up
);

    localparam int             PS_W    = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PS_W-1:0] PS_TERM = PS_W'(TICKS_PER_MIN - 1);
    localparam logic [7:0]     MAX_T   = 8'(MAX_TIME);

    typedef enum logic [2:0] {
        STOPPED,
        RUNNING,
        PROF_PENDING,
        QUIZ_WAIT,
        EXPIRED
    } state_t;

    state_t          state, state_next;
    logic [PS_W-1:0] prescaler;
    logic [7:0]      next_prof;
    logic [7:0]      deadline;
    logic [7:0]      min_next;
    logic [9:0]      gap;
    logic            counting;
    logic            tick;
    logic            schedule;
    logic            load_deadline;
    logic            timeout_fire;

    function automatic logic [7:0] sat255(input logic [9:0] v);
        return (v > 10'd255) ? 8'hFF : v[7:0];
    endfunction

    assign counting = ((state == RUNNING) || (state == PROF_PENDING) || (state == QUIZ_WAIT)) && !hold;
    assign tick     = counting && (prescaler == PS_TERM);
    assign min_next = (tick && (minutes != 8'hFF)) ? minutes + 8'd1 : minutes;

`ifdef PROF_LFSR_EN
    localparam int GAP_RANGE = PROF_MAX_GAP - PROF_MIN_GAP + 1;

    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR, taps 8,6,5,4; clr does not reseed it
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            lfsr <= 8'hA5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign gap = 10'(PROF_MIN_GAP) + 10'(32'(lfsr) % GAP_RANGE);
`else
    assign gap = 10'(PROF_MIN_GAP);
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= STOPPED;
        else
            state <= state_next;
    end

    // Decisions use min_next so a minute landing on the same edge is never missed
    always_comb begin
        state_next    = state;
        schedule      = 1'b0;
        load_deadline = 1'b0;
        timeout_fire  = 1'b0;
        if (clr) begin
            state_next = STOPPED;
        end else begin
            case (state)
                STOPPED: begin
                    if (start) begin
                        state_next = RUNNING;
                        schedule   = 1'b1;
                    end
                end
                RUNNING: begin
                    if (tick && (min_next >= MAX_T))
                        state_next = EXPIRED;
                    else if (tick && (min_next == next_prof))
                        state_next = PROF_PENDING;
                end
                PROF_PENDING: begin
                    if (prof_ack) begin
                        state_next    = QUIZ_WAIT;
                        load_deadline = 1'b1;
                    end
                end
                QUIZ_WAIT: begin
                    if (quiz_done || (minutes >= deadline)) begin
                        timeout_fire = !quiz_done;
                        schedule     = 1'b1;
                        state_next   = (min_next >= MAX_T) ? EXPIRED : RUNNING;
                    end
                end
                EXPIRED: state_next = EXPIRED;
                default: state_next = STOPPED;
            endcase
        end
    end

    always_comb begin
        professor   = (state == PROF_PENDING);
        quiz_active = (state == QUIZ_WAIT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prescaler    <= '0;
            minutes      <= 8'd0;
            min_tick     <= 1'b0;
            time_up      <= 1'b0;
            quiz_timeout <= 1'b0;
            next_prof    <= 8'd0;
            deadline     <= 8'd0;
        end else if (clr) begin
            prescaler    <= '0;
            minutes      <= 8'd0;
            min_tick     <= 1'b0;
            time_up      <= 1'b0;
            quiz_timeout <= 1'b0;
            next_prof    <= 8'd0;
            deadline     <= 8'd0;
        end else begin
            if ((state == STOPPED) || (state == EXPIRED))
                prescaler <= '0;
            else if (counting)
                prescaler <= tick ? '0 : prescaler + 1'b1;
            min_tick     <= tick;
            minutes      <= (state == STOPPED) ? 8'd0 : min_next;
            time_up      <= (state != STOPPED) && (min_next >= MAX_T);
            quiz_timeout <= timeout_fire;
            if (schedule)
                next_prof <= sat255({2'b00, min_next} + gap);
            if (load_deadline)
                deadline <= sat255({2'b00, min_next} + 10'(QUIZ_WINDOW));
        end
    end

endmodule

// File: tb/tb_game_timekeeper.sv
// Directed self-checking bench for game_timekeeper with a 4-cycle minute,
// 20-minute limit, 5-minute professor gap and 3-minute quiz window.
module tb_game_timekeeper;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic       hold = 1'b0;
    logic       prof_ack = 1'b0;
    logic       quiz_done = 1'b0;
    logic [7:0] minutes;
    logic       min_tick;
    logic       professor;
    logic       quiz_active;
    logic       quiz_timeout;
    logic       time_up;

    int total = 0;
    int bad = 0;

    game_timekeeper #(
        .TICKS_PER_MIN(4),
        .MAX_TIME(20),
        .PROF_MIN_GAP(5),
        .PROF_MAX_GAP(25),
        .QUIZ_WINDOW(3)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .clr(clr),
        .hold(hold),
        .prof_ack(prof_ack),
        .quiz_done(quiz_done),
        .minutes(minutes),
        .min_tick(min_tick),
        .professor(professor),
        .quiz_active(quiz_active),
        .quiz_timeout(quiz_timeout),
        .time_up(time_up)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one clock's worth of inputs and returns at the following negedge
    task automatic applyStimulus(input logic s, input logic c, input logic h, input logic a, input logic d);
        start     = s;
        clr       = c;
        hold      = h;
        prof_ack  = a;
        quiz_done = d;
        @(negedge Clk);
    endtask

    task automatic waitMinutes(input logic [7:0] target);
        int n = 0;
        while (minutes !== target && n < 200) begin
            applyStimulus(0, 0, 0, 0, 0);
            n++;
        end
        checkOutput("reachMinutes", 32'(minutes), 32'(target));
    endtask

    initial begin
        int ticks_seen;

        repeat (3) @(negedge Clk);
        checkOutput("resetAll", 32'({minutes, min_tick, professor, quiz_active, quiz_timeout, time_up}), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // First minute arrives four edges after the start edge
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("preTick0", 32'({minutes, min_tick}), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("preTick", 32'({minutes, min_tick}), 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("firstTick", 32'(min_tick), 1);
        checkOutput("firstMinute", 32'(minutes), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("tickPulseEnds", 32'(min_tick), 0);

        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("strayAckIgnored", 32'({professor, quiz_active}), 0);

        waitMinutes(8'd4);
        checkOutput("noProfAt4", 32'(professor), 0);
        waitMinutes(8'd5);
        checkOutput("profAt5", 32'(professor), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("ackProfCleared", 32'(professor), 0);
        checkOutput("ackQuizActive", 32'(quiz_active), 1);
        waitMinutes(8'd6);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("doneQuizClosed", 32'(quiz_active), 0);
        checkOutput("doneNoTimeout", 32'(quiz_timeout), 0);
        waitMinutes(8'd10);
        checkOutput("noProfAt10", 32'(professor), 0);
        waitMinutes(8'd11);
        checkOutput("profAt11", 32'(professor), 1);

        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("clrAll", 32'({minutes, min_tick, professor, quiz_active, quiz_timeout, time_up}), 0);

        // Quiz window runs out: deadline 5+3, next professor 8+5
        applyStimulus(1, 0, 0, 0, 0);
        waitMinutes(8'd5);
        checkOutput("profAt5b", 32'(professor), 1);
        applyStimulus(0, 0, 0, 1, 0);
        waitMinutes(8'd8);
        checkOutput("activeAtDeadline", 32'({quiz_active, quiz_timeout}), 2);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("timeoutPulse", 32'(quiz_timeout), 1);
        checkOutput("timeoutClosed", 32'(quiz_active), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("timeoutEnds", 32'(quiz_timeout), 0);
        waitMinutes(8'd12);
        checkOutput("noProfAt12", 32'(professor), 0);
        waitMinutes(8'd13);
        checkOutput("profAt13", 32'(professor), 1);

        // Prescaler sits at 2 when hold rises; 2 more cycles after release finish minute 14
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        ticks_seen = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            ticks_seen += int'(min_tick);
            checkOutput("holdMinutes", 32'(minutes), 13);
        end
        checkOutput("holdNoTicks", 32'(ticks_seen), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("releaseNotYet", 32'({minutes, min_tick}), 32'({8'd13, 1'b0}));
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("releaseTick", 32'({minutes, min_tick}), 32'({8'd14, 1'b1}));

        waitMinutes(8'd18);
        checkOutput("profAt18", 32'(professor), 1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        waitMinutes(8'd19);
        checkOutput("noTimeUpAt19", 32'(time_up), 0);
        waitMinutes(8'd20);
        checkOutput("timeUpAt20", 32'(time_up), 1);
        checkOutput("tickAt20", 32'(min_tick), 1);
        ticks_seen = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            ticks_seen += int'(min_tick);
        end
        checkOutput("expiredHoldsMin", 32'(minutes), 20);
        checkOutput("expiredTimeUp", 32'(time_up), 1);
        checkOutput("expiredNoTicks", 32'(ticks_seen), 0);
        checkOutput("expiredNoProf", 32'({professor, quiz_active}), 0);

        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("clrFromExpired", 32'({minutes, time_up}), 0);
        ticks_seen = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            ticks_seen += int'(min_tick);
        end
        checkOutput("stoppedIdle", 32'({minutes, 8'(ticks_seen)}), 0);

        // clr wins over quiz_done landing on the same edge
        applyStimulus(1, 0, 0, 0, 0);
        waitMinutes(8'd5);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("quizOpenBeforeClr", 32'(quiz_active), 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("clrDoneAll", 32'({minutes, min_tick, professor, quiz_active, quiz_timeout, time_up}), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("clrDoneNoTimeout", 32'({quiz_timeout, quiz_active}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
